// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//  Shared constants for the common-anode 7-segment display path.
//  Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
//  No ports (package).
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    // Only segment g lit: marks a non-BCD code (A..F) on the display.
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage : seg7_pkg

// File: rtl/bcd_7seg_scan_driver_bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
//  Combinational 4-bit code -> active-low 7-segment pattern.
//  Ports:
//    code  in  4  BCD digit; values A..F decode to a dash
//    seg   out 7  {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7

// File: rtl/bcd_7seg_scan_driver.sv
// ---------------------------------------------------------------------------
// bcd_7seg_scan_driver
//  Time-multiplexes NUM_DIGITS packed BCD digits (plus decimal points) onto
//  a common-anode 7-segment display, one anode at a time. New values are
//  captured into a stage buffer and copied to the displayed shadow buffer
//  only at a frame boundary, so a frame never shows a mix of old and new.
//
//  Optional build macro:
//    LEADING_ZERO_BLANK_EN  blank zero digits above the most significant
//                           nonzero digit (a set dp counts as significant);
//                           digit 0 is always shown.
//
//  Ports:
//    clk         in   1             system clock, rising edge
//    rst_n       in   1             asynchronous, active-low reset
//    en          in   1             1 = scan/display, 0 = blank and freeze
//    digits_i    in   4*NUM_DIGITS  BCD digits, digit 0 in bits [3:0]
//    dp_i        in   NUM_DIGITS    decimal point request, active-high
//    update_i    in   1             capture digits_i/dp_i for display
//    an          out  NUM_DIGITS    anodes, active-low, registered
//    seg         out  7             {g,f,e,d,c,b,a}, active-low, registered
//    dp          out  1             decimal point, active-low, registered
//    frame_done  out  1             pulse on the wrap tick (last digit -> 0)
// ---------------------------------------------------------------------------
module bcd_7seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    update_i,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

    logic [PW-1:0]           presc_p0;
    logic [IW-1:0]           idx_p0;
    logic                    tick;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] stage_dig;
    logic [NUM_DIGITS-1:0]   stage_dp;
    logic [4*NUM_DIGITS-1:0] shadow_dig;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    pending;

    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic [6:0]              cur_seg;
    logic [NUM_DIGITS-1:0]   lead_blank;

    // A tick only exists while enabled, so a disabled scan freezes in place.
    assign tick       = en && (presc_p0 == PRESC_LAST);
    assign wrap       = tick && (idx_p0 == IDX_LAST);
    assign frame_done = wrap;

    // ---- stage p0: prescaler and scan index ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_p0 <= '0;
            idx_p0   <= '0;
        end else if (en) begin
            if (tick) begin
                presc_p0 <= '0;
                idx_p0   <= wrap ? '0 : idx_p0 + IW'(1);
            end else begin
                presc_p0 <= presc_p0 + PW'(1);
            end
        end
    end

    // Stage/shadow double buffer. An update landing exactly on the boundary
    // goes straight to the shadow so it is not held back a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_dig  <= '0;
            stage_dp   <= '0;
            shadow_dig <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else if (update_i) begin
            stage_dig <= digits_i;
            stage_dp  <= dp_i;
            if (wrap) begin
                shadow_dig <= digits_i;
                shadow_dp  <= dp_i;
                pending    <= 1'b0;
            end else begin
                pending    <= 1'b1;
            end
        end else if (wrap && pending) begin
            shadow_dig <= stage_dig;
            shadow_dp  <= stage_dp;
            pending    <= 1'b0;
        end
    end

    assign cur_code = shadow_dig[4*idx_p0 +: 4];
    assign cur_dp   = shadow_dp[idx_p0];

    bcd_to_seg7 u_dec (
        .code (cur_code),
        .seg  (cur_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; everything above the first significant
    // digit (nonzero code or dp set) is blanked. Digit 0 is never examined.
    logic seen;
    always_comb begin
        lead_blank = '0;
        seen       = 1'b0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            if ((shadow_dig[4*k +: 4] != 4'd0) || shadow_dp[k])
                seen = 1'b1;
            lead_blank[k] = ~seen;
        end
    end
`else
    assign lead_blank = '0;
`endif

    // ---- stage p1: registered pin drive ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (!en || lead_blank[idx_p0]) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(AN_ONE << idx_p0);
            seg <= cur_seg;
            dp  <= ~cur_dp;
        end
    end

endmodule : bcd_7seg_scan_driver

// File: tb/tb_bcd_7seg_scan_driver.sv
module tb_bcd_7seg_scan_driver;

    localparam int ND  = 4;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [15:0]   digits_i;
    logic [3:0]    dp_i;
    logic          update_i;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_done;

    int n_vec = 0;
    int n_err = 0;

    bcd_7seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits_i   (digits_i),
        .dp_i       (dp_i),
        .update_i   (update_i),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Segment table straight from the decode list (A..F -> dash).
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // Reference model: one count of enabled cycles, modulo one frame.
    // Digit index = count / DIV, frame boundary = last cycle of the frame.
    int         m_ecnt;
    logic [3:0] m_dig [ND];
    logic [3:0] m_dpv;
    logic [3:0] s_dig [ND];
    logic [3:0] s_dpv;
    logic       m_pend;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;

    function automatic logic is_blanked(int k);
`ifdef LEADING_ZERO_BLANK_EN
        int msd = 0;
        for (int j = 0; j < ND; j++)
            if (m_dig[j] != 0 || m_dpv[j]) msd = j;
        return k > msd;
`else
        return (k < 0);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ecnt = 0;
            m_pend = 1'b0;
            m_dpv  = '0;
            s_dpv  = '0;
            for (int k = 0; k < ND; k++) begin
                m_dig[k] = '0;
                s_dig[k] = '0;
            end
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            int  di;
            logic bnd;
            di  = m_ecnt / DIV;
            bnd = en && (m_ecnt == ND*DIV - 1);
            if (!en || is_blanked(di)) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an  = 4'hF & ~(4'(1) << di);
                e_seg = seg_tab[m_dig[di]];
                e_dp  = ~m_dpv[di];
            end
            if (update_i) begin
                for (int k = 0; k < ND; k++) s_dig[k] = digits_i[4*k +: 4];
                s_dpv = dp_i;
                if (bnd) begin
                    m_dig  = s_dig;
                    m_dpv  = s_dpv;
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end else if (bnd && m_pend) begin
                m_dig  = s_dig;
                m_dpv  = s_dpv;
                m_pend = 1'b0;
            end
            if (en) m_ecnt = (m_ecnt + 1) % (ND*DIV);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_done", 32'(frame_done),
              32'(rst_n && en && (m_ecnt == ND*DIV - 1)));
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        digits_i = d;
        dp_i     = p;
        update_i = 1'b1;
        cyc();
        update_i = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 2*ND*DIV; i++) begin
            if (m_ecnt == p) break;
            cyc();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        digits_i = '0;
        dp_i     = '0;
        update_i = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        en    = 1'b1;
        cyc(40);

        // Mid-frame update, then one on the boundary cycle itself.
        wait_phase(5);
        load(16'h1234, 4'b0100);
        cyc(40);
        wait_phase(ND*DIV - 1);
        load(16'h0987, 4'b0000);
        cyc(20);

        // Two updates inside one frame: only the second survives.
        wait_phase(2);
        load(16'h1111, 4'b0001);
        wait_phase(8);
        load(16'h2222, 4'b1000);
        cyc(40);

        // Non-BCD codes plus a mid-scan disable.
        load(16'hA0B5, 4'b0000);
        cyc(22);
        en = 1'b0;
        cyc(10);
        en = 1'b1;
        cyc(30);

        // Leading-zero patterns (fully displayed unless blanking is built in).
        load(16'h0042, 4'b0000);
        cyc(40);
        load(16'h0000, 4'b0000);
        cyc(40);
        load(16'h0042, 4'b1000);
        cyc(40);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            update_i = ($urandom_range(0, 7) == 0);
            digits_i = 16'($urandom);
            dp_i     = 4'($urandom);
            if ($urandom_range(0, 3) == 0) digits_i = digits_i & 16'h00FF;
            cyc();
        end
        update_i = 1'b0;
        en       = 1'b1;
        cyc(20);

        // Reset mid-frame: pins blank immediately, shadow comes back zeroed.
        load(16'h5555, 4'b0000);
        cyc(20);
        wait_phase(6);
        rst_n = 1'b0;
        #1;
        check("rst_async_an", 32'(an), 32'hF);
        check("rst_async_seg", 32'(seg), 32'h7F);
        check("rst_async_dp", 32'(dp), 32'h1);
        cyc(2);
        rst_n = 1'b1;
        cyc(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bcd_7seg_scan_driver
